// File: rtl/forwarding_unit_pkg.sv
// Shared types for the EXE-stage operand bypass: select encodings and the
// per-stage destination tag carried down the shadow pipeline.
package forwarding_unit_pkg;
  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEM     = 2'b01;
  localparam logic [1:0] FWD_WB      = 2'b10;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic                  wb_en;
    logic                  mem_r_en;
  } stage_tag_t;

  // r0 is hardwired zero, so it never carries a dependency
  function automatic logic tag_match(stage_tag_t t, logic [REG_ADDR_W-1:0] src);
    return t.wb_en && (t.dest == src) && (src != '0);
  endfunction
endpackage

// File: rtl/fwd_select.sv
// One bypass mux select: MEM result beats WB result, regfile otherwise.
module fwd_select
  import forwarding_unit_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  gate,
  input  stage_tag_t            mem_tag,
  input  stage_tag_t            wb_tag,
  input  logic                  forward_en,
  output logic [1:0]            sel
);
  logic unused_ok;
  assign unused_ok = mem_tag.mem_r_en ^ wb_tag.mem_r_en;

  always_comb begin
    sel = FWD_REGFILE;
    if (forward_en && gate) begin
      if (tag_match(mem_tag, src))     sel = FWD_MEM;
      else if (tag_match(wb_tag, src)) sel = FWD_WB;
    end
  end
endmodule

// File: rtl/forwarding_unit.sv
// Operand-bypass select and load-use stall generation, tracking destination
// tags through EXE/MEM/WB in lockstep with the real pipeline registers.
module forwarding_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  forward_en,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_src2_alu,
  input  logic                  id_src2_used,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_wb_en,
  input  logic                  id_mem_r_en,
  output logic [1:0]            val1_forward_sel,
  output logic [1:0]            val2_forward_sel,
  output logic [1:0]            val3_forward_sel,
  output logic                  hazard_detected,
  output logic [CNT_W-1:0]      stall_count
);
  import forwarding_unit_pkg::*;

  stage_tag_t            exe_tag, mem_tag, wb_tag;
  logic [REG_ADDR_W-1:0] exe_src1, exe_src2;
  logic                  exe_src2_alu, exe_src2_used;

  // Lane 0: ALU in1, lane 1: ALU in2, lane 2: store/compare value
  logic [2:0][REG_ADDR_W-1:0] sel_src;
  logic [2:0]                 sel_gate;
  logic [2:0][1:0]            sel_out;

  assign sel_src  = {exe_src2, exe_src2, exe_src1};
  assign sel_gate = {exe_src2_used, exe_src2_alu, 1'b1};

  for (genvar g = 0; g < 3; g++) begin : g_sel
    fwd_select u_sel (
      .src        (sel_src[g]),
      .gate       (sel_gate[g]),
      .mem_tag    (mem_tag),
      .wb_tag     (wb_tag),
      .forward_en (forward_en),
      .sel        (sel_out[g])
    );
  end

  assign val1_forward_sel = sel_out[0];
  assign val2_forward_sel = sel_out[1];
  assign val3_forward_sel = sel_out[2];

  logic use_exe, use_mem;
  always_comb begin
    use_exe = tag_match(exe_tag, id_src1) || (id_src2_used && tag_match(exe_tag, id_src2));
    use_mem = tag_match(mem_tag, id_src1) || (id_src2_used && tag_match(mem_tag, id_src2));
    hazard_detected = 1'b0;
    if (!flush) begin
      // Without bypass, any in-flight producer must drain past MEM first
      if (forward_en) hazard_detected = use_exe && exe_tag.mem_r_en;
      else            hazard_detected = use_exe || use_mem;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_tag       <= '0;
      mem_tag       <= '0;
      wb_tag        <= '0;
      exe_src1      <= '0;
      exe_src2      <= '0;
      exe_src2_alu  <= 1'b0;
      exe_src2_used <= 1'b0;
      stall_count   <= '0;
    end else if (!freeze) begin
      mem_tag <= exe_tag;
      wb_tag  <= mem_tag;
      if (flush || hazard_detected) begin
        exe_tag       <= '0;
        exe_src1      <= '0;
        exe_src2      <= '0;
        exe_src2_alu  <= 1'b0;
        exe_src2_used <= 1'b0;
      end else begin
        exe_tag       <= '{dest: id_dest, wb_en: id_wb_en, mem_r_en: id_mem_r_en};
        exe_src1      <= id_src1;
        exe_src2      <= id_src2;
        exe_src2_alu  <= id_src2_alu;
        exe_src2_used <= id_src2_used;
      end
      if (hazard_detected && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
    end
  end
endmodule

// File: doc/forwarding_unit.md
Name: forwarding_unit

Overview:
- Producer side of the EXE-stage operand-bypass interface: generates `val1_forward_sel`, `val2_forward_sel` and `val3_forward_sel`, plus the load-use stall.
- Keeps its own shadow pipeline of destination tags in step with the ID/EXE, EXE/MEM and MEM/WB pipeline registers. It obeys the same freeze (memory wait) and flush (branch taken) controls as those registers.
- Sits beside the ID stage. Its select outputs drive the EXE stage directly.

Parameters:
- REG_ADDR_W, 5, register-index width.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- freeze  input  1  memory-wait stall; holds every tag stage.
- flush  input  1  branch taken in EXE; squashes the instruction leaving ID.
- forward_en  input  1  1 = bypass enabled; 0 = resolve all hazards by stalling.
- id_src1  input  REG_ADDR_W  ID-stage source register 1.
- id_src2  input  REG_ADDR_W  ID-stage source register 2.
- id_src2_alu  input  1  src2 feeds ALU in2 (0 = immediate).
- id_src2_used  input  1  src2 is read at all (store data, branch compare, or ALU).
- id_dest  input  REG_ADDR_W  ID-stage destination register.
- id_wb_en  input  1  ID instruction writes the register file.
- id_mem_r_en  input  1  ID instruction is a load.
- val1_forward_sel  output  2  00 regfile, 01 MEM result, 10 WB result.
- val2_forward_sel  output  2  same encoding, for ALU in2.
- val3_forward_sel  output  2  same encoding, for store/compare value.
- hazard_detected  output  1  stall IF/ID this cycle; EXE receives a bubble.
- stall_count  output  CNT_W  saturating count of hazard stall cycles.

Behaviour:
- Tag stages. EXE, MEM and WB each hold {dest, wb_en, mem_r_en}. EXE additionally holds {src1, src2, src2_alu, src2_used}.
- On reset (rst low, asynchronous): all stage valid/wb_en/mem_r_en bits = 0, all register fields = 0, stall_count = 0. Consequently all select outputs read 00 and hazard_detected = 0.
- Per rising edge, in priority order:
  - freeze=1: all stages hold; stall_count holds; flush and hazard are ignored.
  - else flush=1: MEM<=EXE, WB<=MEM, EXE<=bubble (all enables 0).
  - else hazard_detected=1: MEM<=EXE, WB<=MEM, EXE<=bubble; stall_count += 1, saturating at all-ones.
  - else: EXE<=ID inputs, MEM<=EXE, WB<=MEM.
- A match condition is defined as: stage.wb_en=1, stage.dest == src, and src != 0. Register 0 never matches.
- Select outputs are combinational from the EXE and MEM/WB tag stages, so they are valid during the same cycle the EXE instruction executes:
  - val1_forward_sel = 01 if match(MEM, exe_src1); else 10 if match(WB, exe_src1); else 00. MEM has priority over WB (youngest producer wins).
  - val2_forward_sel: same rule using exe_src2, gated by exe_src2_alu (00 when exe_src2_alu = 0).
  - val3_forward_sel: same rule using exe_src2, gated by exe_src2_used.
  - All three selects = 00 when forward_en = 0.
- hazard_detected is combinational from the ID inputs and the EXE/MEM tags.
  - A use is src1 always, or src2 when id_src2_used = 1.
  - forward_en=1: asserted when a use matches EXE and exe_mem_r_en = 1 (load-use). Produces exactly one bubble.
  - forward_en=0: asserted when a use matches EXE or MEM. Stalls until the producer passes MEM.
  - Forced to 0 while flush=1, because the ID instruction is being squashed.
  - Not masked by freeze. The pipeline holds anyway.
- An encoding of 11 is never driven.

Decomposition:
- Shared package holds:
  - FWD_REGFILE=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - REG_ADDR_W.
  - A packed stage-tag struct {dest, wb_en, mem_r_en}.
- One natural sub-module, fwd_select: pure combinational comparator. It takes (src, gate, MEM tag, WB tag, forward_en) and returns a 2-bit select. It is instantiated three times.

Test Plan:
- Back-to-back RAW: ADD r3 then SUB r4,r3,r5 (src2_alu=1), forward_en=1 -> in the SUB's EXE cycle val1_forward_sel=01. With one independent instruction between them -> 10. hazard_detected stays 0 throughout.
- Double producer: writes to r3 in both MEM and WB, EXE reads r3 -> val1_forward_sel=01 (MEM priority). Destination r0 in MEM and WB, EXE reads r0 -> 00.
- Load-use: LW r2 followed by ADD r6,r2,r1 -> hazard_detected=1 for exactly 1 cycle and the EXE tag becomes a bubble. The following cycle has val1_forward_sel=10. stall_count increments to 1.
- forward_en=0: ADD r3 followed by SW using r3 as src2 (src2_used=1, src2_alu=0) -> hazard_detected=1 for 2 cycles. All selects stay 00 throughout. stall_count reaches 2.
- Freeze: hold freeze=1 for 4 cycles while a load-use hazard is pending -> tags and stall_count are unchanged. Once freeze drops, exactly one bubble is inserted.
- Flush and reset:
  - Flush with a matching load in EXE -> hazard_detected=0 and EXE<=bubble.
  - rst low mid-stream -> all selects read 00, hazard_detected=0 and stall_count=0 immediately, without waiting for a clock edge.
